// File: rtl/sram_controller.sv
// 32-bit load/store sequencer for a 16-bit asynchronous SRAM.
// Each request becomes a low-half then a high-half access, each held for WAIT_CYCLES clocks.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  logic [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_read_data;

  logic        w_req;
  logic        w_last;
  logic [31:0] w_off;
  logic [16:0] w_word;
  logic [17:0] w_addr;
  logic        w_we_n;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;

  assign w_req  = wr_en | rd_en;
  assign w_off  = address - BASE_ADDR;
  assign w_word = 17'(w_off >> 2);
  assign w_last = (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req)  w_next = S_LOW;
      S_LOW:  if (w_last) w_next = S_HIGH;
      S_HIGH: if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
    endcase
  end

  // Request fields are latched once in IDLE so mid-access input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_is_wr     <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_wr <= wr_en;
            r_word  <= w_word;
            r_wdata <= write_data;
            r_cnt   <= '0;
          end
        end
        S_LOW: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!r_is_wr) r_read_data[15:0] <= SRAM_DQ;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HIGH: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!r_is_wr) r_read_data[31:16] <= SRAM_DQ;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: r_cnt <= '0;
      endcase
    end
  end

  // Bus outputs derive only from registers, so they change solely on rising edges.
  always_comb begin
    w_addr   = {r_word, 1'b0};
    w_we_n   = 1'b1;
    w_dq_oe  = 1'b0;
    w_dq_out = r_wdata[15:0];
    unique case (r_state)
      S_LOW: begin
        w_we_n  = ~r_is_wr;
        w_dq_oe = r_is_wr;
      end
      S_HIGH: begin
        w_addr   = {r_word, 1'b1};
        w_we_n   = ~r_is_wr;
        w_dq_oe  = r_is_wr;
        w_dq_out = r_wdata[31:16];
      end
      default: ;
    endcase
  end

  assign SRAM_ADDR = w_addr;
  assign SRAM_WE_N = w_we_n;
  assign SRAM_DQ   = w_dq_oe ? w_dq_out : 'z;
  assign read_data = r_read_data;
  assign ready     = ~w_req | (r_state == S_DONE);

endmodule
